// File: rtl/cam_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cam_bank_sequencer
// Purpose  : Camera-side write sequencer for the 4-bank 512x32 frame buffer.
//            Packs camera bytes MSB-first into 32-bit words, writes them to
//            the bank being filled, and keeps a per-bank "holds unread data"
//            flag that the host clears with a release pulse.
// Ports    : PCLKI          pixel clock (rising edge)
//            WBs_RST_i      asynchronous active-high reset
//            VSYNCI/HREFI   frame / line valid; byte valid = VSYNCI & HREFI
//            CAM_DAT_i      pixel byte
//            arm_i          arms capture of the next frame (PCLKI domain)
//            bank_release_i per-bank host-drained pulse (PCLKI domain)
//            ram_wa_o/wd_o  shared write address / data to the banks
//            ram_wen_o      one-hot bank write enable
//            cur_bank_o     bank being filled
//            bank_full_o    sticky per-bank unread-data flags
//            frame_done_o   1-cycle pulse at end of a captured frame
//            overflow_o     sticky, cleared by reset or arm_i
//            state_o        0 IDLE, 1 ARMED, 2 CAPT, 3 DROP
// Config   : CAM_SEQ_FREERUN_EN - re-arm automatically after every frame.
// Revision : 1.0 - initial release
// ============================================================================
module cam_bank_sequencer #(
  parameter int BANK_AW   = 9,
  parameter int NUM_BANKS = 4
) (
  input  logic               PCLKI,
  input  logic               WBs_RST_i,
  input  logic               VSYNCI,
  input  logic               HREFI,
  input  logic [7:0]         CAM_DAT_i,
  input  logic               arm_i,
  input  logic [3:0]         bank_release_i,
  output logic [BANK_AW-1:0] ram_wa_o,
  output logic [31:0]        ram_wd_o,
  output logic [3:0]         ram_wen_o,
  output logic [1:0]         cur_bank_o,
  output logic [3:0]         bank_full_o,
  output logic               frame_done_o,
  output logic               overflow_o,
  output logic [1:0]         state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

`ifdef CAM_SEQ_FREERUN_EN
  localparam logic [1:0] S_AFTER_FRAME = S_ARMED;
`else
  localparam logic [1:0] S_AFTER_FRAME = S_IDLE;
`endif

  localparam logic [BANK_AW-1:0] LAST_WORD = '1;
  localparam logic [BANK_AW-1:0] WORD_ONE  = {{(BANK_AW-1){1'b0}}, 1'b1};
  localparam logic [1:0]         LAST_BANK = 2'(NUM_BANKS - 1);

  logic [1:0]         state;
  logic               vs_d;
  logic [1:0]         byte_cnt;
  logic [23:0]        pack;      // first three bytes of the word in flight
  logic [BANK_AW-1:0] word_cnt;
  logic [1:0]         cur_bank;
  logic [3:0]         bank_full;
  logic               overflow;

  logic               vs_rise;
  logic               vs_fall;
  logic               byte_vld;
  logic               word_rdy;
  logic [1:0]         next_bank;
  logic [3:0]         cur_onehot;
  logic [3:0]         bank_set;

  assign vs_rise    = VSYNCI & ~vs_d;
  assign vs_fall    = ~VSYNCI & vs_d;
  assign byte_vld   = VSYNCI & HREFI;
  assign word_rdy   = (state == S_CAPT) && byte_vld && (byte_cnt == 2'd3);
  assign next_bank  = (cur_bank == LAST_BANK) ? 2'd0 : cur_bank + 2'd1;
  assign cur_onehot = 4'b0001 << cur_bank;

  // Banks that become full this cycle: last word of a bank written, or a
  // frame ending with a partly filled bank.
  always_comb begin
    bank_set = 4'b0000;
    if (word_rdy && !bank_full[cur_bank] && (word_cnt == LAST_WORD)) begin
      bank_set = cur_onehot;
    end else if ((state == S_CAPT) && vs_fall && (word_cnt != '0)) begin
      bank_set = cur_onehot;
    end
  end

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state        <= S_IDLE;
      vs_d         <= 1'b0;
      byte_cnt     <= 2'd0;
      pack         <= '0;
      word_cnt     <= '0;
      cur_bank     <= 2'd0;
      bank_full    <= 4'b0000;
      overflow     <= 1'b0;
      frame_done_o <= 1'b0;
      ram_wen_o    <= 4'b0000;
      ram_wa_o     <= '0;
      ram_wd_o     <= '0;
    end else begin
      vs_d         <= VSYNCI;
      frame_done_o <= 1'b0;
      ram_wen_o    <= 4'b0000;
      // Set beats release when both hit the same bank in one cycle.
      bank_full    <= (bank_full & ~bank_release_i) | bank_set;

      if ((state != S_CAPT) || vs_rise) begin
        byte_cnt <= 2'd0;
      end else if (byte_vld) begin
        byte_cnt <= byte_cnt + 2'd1;
        pack     <= {pack[15:0], CAM_DAT_i};
      end

`ifdef CAM_SEQ_FREERUN_EN
      if (arm_i) begin
        overflow <= 1'b0;
      end
`endif

      case (state)
        S_IDLE: begin
          if (arm_i) begin
            state    <= S_ARMED;
            overflow <= 1'b0;
            word_cnt <= '0;
            cur_bank <= 2'd0;
          end
        end
        S_ARMED: begin
          if (vs_rise) begin
            state <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (vs_fall) begin
            frame_done_o <= 1'b1;
            word_cnt     <= '0;
            state        <= S_AFTER_FRAME;
            if (word_cnt != '0) begin
              cur_bank <= next_bank;
            end
          end else if (word_rdy) begin
            if (bank_full[cur_bank]) begin
              // Bank still unread (e.g. re-armed onto bank 0 without a
              // release): never overwrite it.
              overflow <= 1'b1;
              state    <= S_DROP;
            end else begin
              ram_wen_o <= cur_onehot;
              ram_wa_o  <= word_cnt;
              ram_wd_o  <= {pack, CAM_DAT_i};
              word_cnt  <= word_cnt + WORD_ONE;
              if (word_cnt == LAST_WORD) begin
                cur_bank <= next_bank;
                if (bank_full[next_bank]) begin
                  overflow <= 1'b1;
                  state    <= S_DROP;
                end
              end
            end
          end
        end
        S_DROP: begin
          if (vs_fall) begin
            frame_done_o <= 1'b1;
            state        <= S_AFTER_FRAME;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cur_bank_o  = cur_bank;
  assign bank_full_o = bank_full;
  assign overflow_o  = overflow;
  assign state_o     = state;

endmodule
`default_nettype wire

// File: tb/tb_cam_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_bank_sequencer
// Purpose  : Directed bench for cam_bank_sequencer. A byte-queue model of the
//            capture rules predicts every output each cycle; literal checks
//            pin pack order, rollover, overflow, release race, partial word
//            discard and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_bank_sequencer;

  logic        PCLKI = 1'b0;
  logic        WBs_RST_i = 1'b1;
  logic        VSYNCI = 1'b0;
  logic        HREFI = 1'b0;
  logic [7:0]  CAM_DAT_i = 8'h00;
  logic        arm_i = 1'b0;
  logic [3:0]  bank_release_i = 4'b0000;
  logic [8:0]  ram_wa_o;
  logic [31:0] ram_wd_o;
  logic [3:0]  ram_wen_o;
  logic [1:0]  cur_bank_o;
  logic [3:0]  bank_full_o;
  logic        frame_done_o;
  logic        overflow_o;
  logic [1:0]  state_o;

  cam_bank_sequencer #(.BANK_AW(9), .NUM_BANKS(4)) dut (
    .PCLKI(PCLKI), .WBs_RST_i(WBs_RST_i), .VSYNCI(VSYNCI), .HREFI(HREFI),
    .CAM_DAT_i(CAM_DAT_i), .arm_i(arm_i), .bank_release_i(bank_release_i),
    .ram_wa_o(ram_wa_o), .ram_wd_o(ram_wd_o), .ram_wen_o(ram_wen_o),
    .cur_bank_o(cur_bank_o), .bank_full_o(bank_full_o),
    .frame_done_o(frame_done_o), .overflow_o(overflow_o), .state_o(state_o)
  );

  always #5 PCLKI = ~PCLKI;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int DEPTH = 512;
  bit [1:0]   m_state;
  bit         m_vs_prev;
  logic [7:0] m_q[$];
  int         m_word;
  bit [1:0]   m_bank;
  bit [3:0]   m_full;
  bit         m_over, m_done;
  bit [3:0]   m_wen;
  bit [8:0]   m_wa;
  bit [31:0]  m_wd;

  task automatic model_step();
    bit rise, fall;
    bit [3:0] set_b;
    bit [1:0] st;
    if (WBs_RST_i) begin
      m_state = 0; m_vs_prev = 0; m_q.delete(); m_word = 0; m_bank = 0;
      m_full = 0; m_over = 0; m_done = 0; m_wen = 0; m_wa = 0; m_wd = 0;
      return;
    end
    rise  = VSYNCI && !m_vs_prev;
    fall  = !VSYNCI && m_vs_prev;
    set_b = 4'b0000;
    st    = m_state;
    m_done = 0;
    m_wen  = 0;
    if (st != 2) m_q.delete();
    case (st)
      2'd0: if (arm_i) begin m_state = 1; m_over = 0; m_word = 0; m_bank = 0; end
      2'd1: if (rise) m_state = 2;
      2'd2: begin
        if (fall) begin
          m_q.delete();
          if (m_word > 0) begin set_b[m_bank] = 1'b1; m_bank = m_bank + 2'd1; end
          m_done = 1; m_word = 0; m_state = 0;
        end else if (VSYNCI && HREFI) begin
          m_q.push_back(CAM_DAT_i);
          if (m_q.size() == 4) begin
            if (m_full[m_bank]) begin
              m_over = 1; m_state = 3;
            end else begin
              m_wen = 4'b0001 << m_bank;
              m_wa  = 9'(m_word);
              m_wd  = {m_q[0], m_q[1], m_q[2], m_q[3]};
              m_word++;
              if (m_word == DEPTH) begin
                set_b[m_bank] = 1'b1;
                m_word = 0;
                m_bank = m_bank + 2'd1;
                if (m_full[m_bank]) begin m_over = 1; m_state = 3; end
              end
            end
            m_q.delete();
          end
        end
      end
      2'd3: if (fall) begin m_done = 1; m_state = 0; end
      default: ;
    endcase
    m_full    = (m_full & ~bank_release_i) | set_b;
    m_vs_prev = VSYNCI;
  endtask

  initial begin
    forever begin
      @(posedge PCLKI or posedge WBs_RST_i);
      model_step();
    end
  end

  // ---------------- per-cycle compare and write log ----------------
  typedef struct {
    logic [3:0]  wen;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic [3:0]  full;
  } wr_t;
  wr_t wlog[$];
  int  done_cnt = 0;

  wire [54:0] dut_bus = {ram_wen_o, ram_wa_o, ram_wd_o, cur_bank_o, bank_full_o,
                         frame_done_o, overflow_o, state_o};
  wire [54:0] mdl_bus = {m_wen, m_wa, m_wd, m_bank, m_full, m_done, m_over, m_state};

  initial begin
    forever begin
      @(posedge PCLKI);
      #1;
      chk("cycle wen|wa|wd|bank|full|done|ovf|state", 64'(dut_bus), 64'(mdl_bus));
      if (ram_wen_o != 4'b0000) wlog.push_back('{ram_wen_o, ram_wa_o, ram_wd_o, bank_full_o});
      if (frame_done_o) done_cnt++;
    end
  end

  // ---------------- stimulus helpers (inputs change at negedge) ----------------
  task automatic idle(input int n);
    HREFI = 1'b0; arm_i = 1'b0; bank_release_i = 4'b0000;
    repeat (n) @(negedge PCLKI);
  endtask

  task automatic pulse_arm();
    arm_i = 1'b1; @(negedge PCLKI); arm_i = 1'b0;
  endtask

  task automatic release_banks(input logic [3:0] b);
    bank_release_i = b; @(negedge PCLKI); bank_release_i = 4'b0000;
  endtask

  task automatic frame_start();
    VSYNCI = 1'b1; HREFI = 1'b0; repeat (2) @(negedge PCLKI);
  endtask

  task automatic send_byte(input logic [7:0] d);
    HREFI = 1'b1; CAM_DAT_i = d; @(negedge PCLKI); HREFI = 1'b0;
  endtask

  task automatic frame_end();
    HREFI = 1'b0; @(negedge PCLKI);
    VSYNCI = 1'b0; repeat (3) @(negedge PCLKI);
  endtask

  int d0;
  logic [7:0] t1_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    // reset state
    repeat (3) @(negedge PCLKI);
    chk("reset outputs", 64'(dut_bus), 64'd0);
    WBs_RST_i = 1'b0;
    idle(2);

    // T1 pack: gaps with junk data on HREFI low
    wlog.delete(); d0 = done_cnt;
    pulse_arm(); idle(1);
    frame_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(t1_bytes[i]);
      CAM_DAT_i = 8'hFF; @(negedge PCLKI);
    end
    frame_end();
    chk("T1 write count", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("T1 w0 wen", 64'(wlog[0].wen), 64'h1);
      chk("T1 w0 wa",  64'(wlog[0].wa),  64'd0);
      chk("T1 w0 wd",  64'(wlog[0].wd),  64'h11223344);
      chk("T1 w1 wa",  64'(wlog[1].wa),  64'd1);
      chk("T1 w1 wd",  64'(wlog[1].wd),  64'h55667788);
    end
    chk("T1 frame_done", 64'(done_cnt - d0), 64'd1);
    chk("T1 bank_full", 64'(bank_full_o), 64'h1);
    chk("T1 cur_bank", 64'(cur_bank_o), 64'd1);
    chk("T1 state", 64'(state_o), 64'd0);
    release_banks(4'b0001); idle(1);
    chk("release clears", 64'(bank_full_o), 64'h0);
    release_banks(4'b0100); idle(1);
    chk("release of empty bank", 64'(bank_full_o), 64'h0);

    // T2 rollover + T4 release race on the cycle bank 0 fills
    wlog.delete();
    pulse_arm(); idle(1);
    frame_start();
    for (int i = 0; i < 2052; i++) begin
      bank_release_i = (i == 2047) ? 4'b0001 : 4'b0000;
      send_byte(i[7:0]);
    end
    bank_release_i = 4'b0000;
    frame_end();
    chk("T2 write count", 64'(wlog.size()), 64'd513);
    if (wlog.size() == 513) begin
      chk("T2 w510 full", 64'(wlog[510].full), 64'h0);
      chk("T2 w511 wa", 64'(wlog[511].wa), 64'd511);
      chk("T2 w511 wd", 64'(wlog[511].wd), 64'hFCFDFEFF);
      chk("T2 w511 full", 64'(wlog[511].full), 64'h1);
      chk("T2 w512 wen", 64'(wlog[512].wen), 64'h2);
      chk("T2 w512 wa", 64'(wlog[512].wa), 64'd0);
      chk("T4 race full kept", 64'(wlog[512].full[0]), 64'd1);
    end
    chk("T2 bank_full end", 64'(bank_full_o), 64'h3);
    release_banks(4'b0001); idle(1);
    chk("T4 later release", 64'(bank_full_o), 64'h2);
    release_banks(4'b0010); idle(1);

    // T3 overflow: four full banks then four more bytes
    wlog.delete(); d0 = done_cnt;
    pulse_arm(); idle(1);
    frame_start();
    for (int i = 0; i < 8196; i++) send_byte(i[7:0]);
    idle(1);
    chk("T3 overflow", 64'(overflow_o), 64'd1);
    chk("T3 state DROP", 64'(state_o), 64'd3);
    chk("T3 write count", 64'(wlog.size()), 64'd2048);
    if (wlog.size() == 2048) chk("T3 last wen", 64'(wlog[2047].wen), 64'h8);
    chk("T3 bank_full", 64'(bank_full_o), 64'hF);
    frame_end();
    chk("T3 frame_done", 64'(done_cnt - d0), 64'd1);
    chk("T3 state IDLE", 64'(state_o), 64'd0);
    chk("T3 overflow sticky", 64'(overflow_o), 64'd1);
    release_banks(4'b1111); idle(1);

    // T5 partial word
    wlog.delete();
    pulse_arm(); idle(1);
    chk("arm clears overflow", 64'(overflow_o), 64'd0);
    frame_start();
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    frame_end();
    chk("T5 write count", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) begin
      chk("T5 wa", 64'(wlog[0].wa), 64'd0);
      chk("T5 wd", 64'(wlog[0].wd), 64'hA0A1A2A3);
    end
    chk("T5 bank_full", 64'(bank_full_o), 64'h1);
    release_banks(4'b0001); idle(1);

    // T6 asynchronous reset mid-capture
    pulse_arm(); idle(1);
    frame_start();
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
    HREFI = 1'b1;
    #2 WBs_RST_i = 1'b1;
    #1 chk("T6 async reset outputs", 64'(dut_bus), 64'd0);
    repeat (2) @(negedge PCLKI);
    WBs_RST_i = 1'b0;
    HREFI = 1'b0;
    wlog.delete();
    for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i));
    pulse_arm();
    for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i));
    chk("T6 no writes before rise", 64'(wlog.size()), 64'd0);
    chk("T6 armed waits", 64'(state_o), 64'd1);
    frame_end();
    frame_start();
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    frame_end();
    chk("T6 write count", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) begin
      chk("T6 wen", 64'(wlog[0].wen), 64'h1);
      chk("T6 wd", 64'(wlog[0].wd), 64'hC0C1C2C3);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
